// File: rtl/ibex_register_file_l1_cached.sv
// ibex_register_file_l1_cached
//
// Two-level register file for the ID stage. A small fully-associative L1
// register cache sits in front of a full-depth backing array. The backing
// array models a slow SRAM with a fixed read latency. A read that misses in
// L1 raises reg_stall_o while a fill brings the register into L1.
//
// Ports:
//   clk_i               clock
//   rst_i               synchronous active-high reset
//   req_a_i / req_b_i   read request valid, ports A / B
//   raddr_a_i/raddr_b_i read addresses (bit 4 ignored when RV32E=1)
//   rdata_a_o/rdata_b_o read data; valid when req=1 and reg_stall_o=0
//   we_a_i, waddr_a_i,  write port; never stalled, write-through
//   wdata_a_i
//   reg_stall_o         a requested read cannot be served this cycle
//   miss_count_o        completed L1 fills, saturating
module ibex_register_file_l1_cached #(
    parameter bit          RV32E        = 1'b0,
    parameter int unsigned DataWidth    = 32,
    parameter int unsigned NumL1Entries = 4,
    parameter int unsigned MissLatency  = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 req_a_i,
    input  logic [4:0]           raddr_a_i,
    output logic [DataWidth-1:0] rdata_a_o,
    input  logic                 req_b_i,
    input  logic [4:0]           raddr_b_i,
    output logic [DataWidth-1:0] rdata_b_o,
    input  logic                 we_a_i,
    input  logic [4:0]           waddr_a_i,
    input  logic [DataWidth-1:0] wdata_a_i,
    output logic                 reg_stall_o,
    output logic [31:0]          miss_count_o
);

    localparam int unsigned AddrWidth = RV32E ? 4 : 5;
    localparam int unsigned NumRegs   = 2 ** AddrWidth;
    localparam int unsigned PtrWidth  = $clog2(NumL1Entries);

    localparam logic [3:0]          LatInit   = 4'(MissLatency);
    localparam logic [PtrWidth-1:0] LastEntry = PtrWidth'(NumL1Entries - 1);

    typedef enum logic {
        IDLE,
        FILL
    } state_e;

    // Effective addresses (MSB dropped for RV32E).
    logic [AddrWidth-1:0] addr_a, addr_b, waddr;
    assign addr_a = raddr_a_i[AddrWidth-1:0];
    assign addr_b = raddr_b_i[AddrWidth-1:0];
    assign waddr  = waddr_a_i[AddrWidth-1:0];

    // Storage
    logic [DataWidth-1:0] backing_q  [NumRegs];
    logic                 l1_valid_q [NumL1Entries];
    logic [AddrWidth-1:0] l1_tag_q   [NumL1Entries];
    logic [DataWidth-1:0] l1_data_q  [NumL1Entries];
    logic [PtrWidth-1:0]  rr_q;
    logic [31:0]          miss_count_q;

    // FSM
    state_e               state_q, state_d;
    logic [3:0]           cnt_q, cnt_d;
    logic [AddrWidth-1:0] fill_addr_q, fill_addr_d;
    logic                 install;

    // L1 lookup
    logic                 hit_a, hit_b;
    logic [DataWidth-1:0] data_a, data_b;
    logic                 l1_whit [NumL1Entries];

    // NOTE: every signal driven in an always_comb gets a default before any
    // conditional assignment, otherwise a path that skips it infers a latch.
    always_comb begin
        hit_a  = 1'b0;
        hit_b  = 1'b0;
        data_a = '0;
        data_b = '0;
        for (int i = 0; i < NumL1Entries; i++) begin
            l1_whit[i] = l1_valid_q[i] && (l1_tag_q[i] == waddr);
            if (l1_valid_q[i] && (l1_tag_q[i] == addr_a)) begin
                hit_a  = 1'b1;
                data_a = l1_data_q[i];
            end
            if (l1_valid_q[i] && (l1_tag_q[i] == addr_b)) begin
                hit_b  = 1'b1;
                data_b = l1_data_q[i];
            end
        end
    end

    // x0 always hits and reads zero; it is never allocated in L1.
    logic a_is_zero, b_is_zero, miss_a, miss_b, we_valid;
    assign a_is_zero = (addr_a == '0);
    assign b_is_zero = (addr_b == '0);
    assign miss_a    = req_a_i && !a_is_zero && !hit_a;
    assign miss_b    = req_b_i && !b_is_zero && !hit_b;
    assign we_valid  = we_a_i && (waddr != '0);

    assign rdata_a_o    = (rst_i || a_is_zero) ? '0 : data_a;
    assign rdata_b_o    = (rst_i || b_is_zero) ? '0 : data_b;
    assign reg_stall_o  = !rst_i && (miss_a || miss_b || (state_q != IDLE));
    assign miss_count_o = miss_count_q;

    // A write to the fill address in the install cycle must win over the
    // stale backing value, since both land on the same edge.
    logic [DataWidth-1:0] fill_data;
    assign fill_data = (we_valid && (waddr == fill_addr_q)) ? wdata_a_i
                                                            : backing_q[fill_addr_q];

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        fill_addr_d = fill_addr_q;
        install     = 1'b0;
        unique case (state_q)
            IDLE: begin
                // Port A wins; if both miss the same register one fill serves both.
                if (miss_a || miss_b) begin
                    state_d     = FILL;
                    fill_addr_d = miss_a ? addr_a : addr_b;
                    cnt_d       = LatInit;
                end
            end
            FILL: begin
                if (cnt_q == 4'd1) begin
                    install = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state is updated with non-blocking assignments so every
    // flop samples pre-edge values regardless of statement order.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            fill_addr_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            fill_addr_q <= fill_addr_d;
        end
    end

    // Backing array, valid bits, replacement pointer and fill counter.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < NumRegs; i++) backing_q[i] <= '0;
            for (int i = 0; i < NumL1Entries; i++) l1_valid_q[i] <= 1'b0;
            rr_q         <= '0;
            miss_count_q <= '0;
        end else begin
            if (we_valid) backing_q[waddr] <= wdata_a_i;
            if (install) begin
                l1_valid_q[rr_q] <= 1'b1;
                rr_q             <= (rr_q == LastEntry) ? '0 : rr_q + 1'b1;
                if (miss_count_q != '1) miss_count_q <= miss_count_q + 32'd1;
            end
        end
    end

    // NOTE: L1 tags and data have no reset; the cleared valid bits make their
    // contents unobservable, so resetting them would only cost reset fan-out.
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < NumL1Entries; i++) begin
            if (we_valid && l1_whit[i]) l1_data_q[i] <= wdata_a_i;
        end
        // Install is last so it overrides a write hit on the victim entry.
        if (install) begin
            l1_tag_q[rr_q]  <= fill_addr_q;
            l1_data_q[rr_q] <= fill_data;
        end
    end

endmodule

// File: tb/tb_ibex_register_file_l1_cached.sv
// Directed bench for ibex_register_file_l1_cached with default parameters
// (32 registers, 4 L1 entries, MissLatency=2). Inputs change on the falling
// edge; outputs are sampled 1 time unit later.
module tb_ibex_register_file_l1_cached;

    localparam int Lat = 2;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        req_a_i, req_b_i, we_a_i;
    logic [4:0]  raddr_a_i, raddr_b_i, waddr_a_i;
    logic [31:0] wdata_a_i, rdata_a_o, rdata_b_o, miss_count_o;
    logic        reg_stall_o;

    int total = 0;
    int bad   = 0;

    always #5 clk_i = ~clk_i;

    ibex_register_file_l1_cached #(
        .RV32E(1'b0), .DataWidth(32), .NumL1Entries(4), .MissLatency(Lat)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .req_a_i(req_a_i), .raddr_a_i(raddr_a_i), .rdata_a_o(rdata_a_o),
        .req_b_i(req_b_i), .raddr_b_i(raddr_b_i), .rdata_b_o(rdata_b_o),
        .we_a_i(we_a_i), .waddr_a_i(waddr_a_i), .wdata_a_i(wdata_a_i),
        .reg_stall_o(reg_stall_o), .miss_count_o(miss_count_o)
    );

    typedef struct {
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic        ra;
        logic [4:0]  aa;
        logic        rb;
        logic [4:0]  ab;
        logic        stall;
        logic        ca;
        logic [31:0] ea;
        logic        cb;
        logic [31:0] eb;
        logic [31:0] mc;
    } vec_t;

    vec_t vq[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic we, input logic [4:0] waddr, input logic [31:0] wdata,
                       input logic ra, input logic [4:0] aa, input logic rb, input logic [4:0] ab,
                       input logic stall, input logic ca, input logic [31:0] ea,
                       input logic cb, input logic [31:0] eb, input logic [31:0] mc);
        vec_t v;
        v.we = we; v.waddr = waddr; v.wdata = wdata;
        v.ra = ra; v.aa = aa; v.rb = rb; v.ab = ab;
        v.stall = stall; v.ca = ca; v.ea = ea; v.cb = cb; v.eb = eb; v.mc = mc;
        vq.push_back(v);
    endtask

    task automatic set_in(input logic we, input logic [4:0] waddr, input logic [31:0] wdata,
                          input logic ra, input logic [4:0] aa,
                          input logic rb, input logic [4:0] ab);
        we_a_i = we; waddr_a_i = waddr; wdata_a_i = wdata;
        req_a_i = ra; raddr_a_i = aa; req_b_i = rb; raddr_b_i = ab;
    endtask

    // Read addr on port A from a cold miss: Lat+1 stalled cycles, then data.
    task automatic do_fill(input logic [4:0] addr, input logic [31:0] exp, input logic [31:0] mc0);
        for (int k = 0; k <= Lat; k++) begin
            set_in(0, 0, 0, 1, addr, 0, 0);
            #1;
            check($sformatf("fill x%0d stall c%0d", addr, k), 32'(reg_stall_o), 32'd1);
            if (k == 0) check($sformatf("fill x%0d mc before", addr), miss_count_o, mc0);
            @(negedge clk_i);
        end
        set_in(0, 0, 0, 1, addr, 0, 0);
        #1;
        check($sformatf("fill x%0d stall done", addr), 32'(reg_stall_o), 32'd0);
        check($sformatf("fill x%0d data", addr), rdata_a_o, exp);
        check($sformatf("fill x%0d mc after", addr), miss_count_o, mc0 + 32'd1);
        @(negedge clk_i);
    endtask

    task automatic do_reset(input int cycles);
        rst_i = 1'b1;
        set_in(0, 0, 0, 1, 5'd5, 1, 5'd6);
        for (int k = 0; k < cycles; k++) begin
            #1;
            check("reset stall", 32'(reg_stall_o), 32'd0);
            check("reset rdata_a", rdata_a_o, 32'd0);
            check("reset rdata_b", rdata_b_o, 32'd0);
            @(negedge clk_i);
        end
        rst_i = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        //   we wa  wdata          ra aa  rb ab  st ca ea             cb eb        mc
        add(0, 0,  0,            1, 5,  0, 0,  1, 0, 0,            0, 0,        0);
        add(0, 0,  0,            1, 5,  0, 0,  1, 0, 0,            0, 0,        0);
        add(0, 0,  0,            1, 5,  0, 0,  1, 0, 0,            0, 0,        0);
        add(1, 5,  32'hDEADBEEF, 1, 5,  0, 0,  0, 1, 0,            0, 0,        1);
        add(0, 0,  0,            1, 5,  0, 0,  0, 1, 32'hDEADBEEF, 0, 0,        1);
        add(1, 7,  32'h1234,     0, 0,  0, 0,  0, 0, 0,            0, 0,        1);
        add(1, 1,  32'h11,       1, 5,  1, 7,  1, 0, 0,            0, 0,        1);
        add(1, 2,  32'h22,       1, 5,  1, 7,  1, 0, 0,            0, 0,        1);
        add(1, 3,  32'h33,       1, 5,  1, 7,  1, 0, 0,            0, 0,        1);
        add(0, 0,  0,            1, 5,  1, 7,  0, 1, 32'hDEADBEEF, 1, 32'h1234, 2);
        add(0, 0,  0,            1, 1,  1, 2,  1, 0, 0,            0, 0,        2);
        add(0, 0,  0,            1, 1,  1, 2,  1, 0, 0,            0, 0,        2);
        add(0, 0,  0,            1, 1,  1, 2,  1, 0, 0,            0, 0,        2);
        add(0, 0,  0,            1, 1,  1, 2,  1, 0, 0,            0, 0,        3);
        add(0, 0,  0,            1, 1,  1, 2,  1, 0, 0,            0, 0,        3);
        add(0, 0,  0,            1, 1,  1, 2,  1, 0, 0,            0, 0,        3);
        add(0, 0,  0,            1, 1,  1, 2,  0, 1, 32'h11,       1, 32'h22,   4);
        add(0, 0,  0,            1, 3,  0, 0,  1, 0, 0,            0, 0,        4);
        add(0, 0,  0,            1, 3,  0, 0,  1, 0, 0,            0, 0,        4);
        add(1, 3,  32'hA5A5,     1, 3,  0, 0,  1, 0, 0,            0, 0,        4);
        add(0, 0,  0,            1, 3,  0, 0,  0, 1, 32'hA5A5,     0, 0,        5);
        add(0, 0,  0,            1, 4,  0, 0,  1, 0, 0,            0, 0,        5);
        add(1, 4,  32'h44,       1, 4,  0, 0,  1, 0, 0,            0, 0,        5);
        add(0, 0,  0,            1, 4,  0, 0,  1, 0, 0,            0, 0,        5);
        add(0, 0,  0,            1, 4,  0, 0,  0, 1, 32'h44,       0, 0,        6);
        add(1, 0,  32'hFFFF,     1, 0,  1, 0,  0, 1, 0,            1, 0,        6);
        add(0, 0,  0,            1, 0,  1, 0,  0, 1, 0,            1, 0,        6);
        add(0, 0,  0,            0, 20, 0, 21, 0, 0, 0,            0, 0,        6);
        add(1, 3,  32'hBEEF,     1, 3,  0, 0,  0, 1, 32'hA5A5,     0, 0,        6);
        add(0, 0,  0,            1, 3,  0, 0,  0, 1, 32'hBEEF,     0, 0,        6);

        do_reset(2);

        for (int i = 0; i < vq.size(); i++) begin
            set_in(vq[i].we, vq[i].waddr, vq[i].wdata, vq[i].ra, vq[i].aa, vq[i].rb, vq[i].ab);
            #1;
            check($sformatf("v%0d stall", i), 32'(reg_stall_o), 32'(vq[i].stall));
            check($sformatf("v%0d miss_count", i), miss_count_o, vq[i].mc);
            if (vq[i].ca) check($sformatf("v%0d rdata_a", i), rdata_a_o, vq[i].ea);
            if (vq[i].cb) check($sformatf("v%0d rdata_b", i), rdata_b_o, vq[i].eb);
            @(negedge clk_i);
        end

        // Reset in the middle of a fill of x6: nothing installed, count cleared.
        set_in(0, 0, 0, 1, 5'd6, 0, 0);
        #1;
        check("x6 detect stall", 32'(reg_stall_o), 32'd1);
        @(negedge clk_i);
        do_reset(1);
        do_fill(5'd6, 32'd0, 32'd0);

        // Round-robin eviction: x1..x4 fill the L1, x9 evicts x1.
        do_reset(1);
        for (int r = 1; r <= 4; r++) begin
            set_in(1, 5'(r), 32'h100 + 32'(r), 0, 0, 0, 0);
            @(negedge clk_i);
        end
        set_in(1, 5'd9, 32'h109, 0, 0, 0, 0);
        @(negedge clk_i);
        for (int r = 1; r <= 4; r++) do_fill(5'(r), 32'h100 + 32'(r), 32'(r - 1));
        do_fill(5'd9, 32'h109, 32'd4);
        set_in(0, 0, 0, 1, 5'd2, 0, 0);
        #1;
        check("evict x2 hit stall", 32'(reg_stall_o), 32'd0);
        check("evict x2 hit data", rdata_a_o, 32'h102);
        @(negedge clk_i);
        do_fill(5'd1, 32'h101, 32'd5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
